// File: rtl/pad_feed_ctrl.sv
// pad_feed_ctrl
//   Feeds SIZE x SIZE pixel maps from memory into a downstream padding stage,
//   one pixel read every GAP+1 cycles, for `frames` maps per job. It then waits
//   for the padding stage to emit its (SIZE+2*PADDING)^2 outputs plus pad_end
//   before moving to the next map.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   start, abort      : job request (one cycle) / cancel the running job
//   base_addr, frames : first pixel address and number of maps per job
//   busy, done, err   : job running / one-cycle completion / sticky error
//   mem_rd_en/addr    : pixel read request; mem_rd_data returns one cycle later
//   pad_ce, pad_vld,
//   pad_din           : padding stage enable, input strobe and pixel
//   pad_dout_vld,
//   pad_end           : padding stage output strobe and end-of-map flag
module pad_feed_ctrl #(
  parameter int N       = 8,
  parameter int CHANNEL = 3,
  parameter int SIZE    = 32,
  parameter int PADDING = 1,
  parameter int GAP     = 13,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [7:0]             frames,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   mem_rd_en,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic [CHANNEL*N-1:0]   mem_rd_data,
  output logic                   pad_ce,
  output logic                   pad_vld,
  output logic [CHANNEL*N-1:0]   pad_din,
  input  logic                   pad_dout_vld,
  input  logic                   pad_end
);

  localparam int TOTAL_RD  = SIZE * SIZE;
  localparam int TOTAL_OUT = (SIZE + 2 * PADDING) * (SIZE + 2 * PADDING);
  localparam int RD_W      = $clog2(TOTAL_RD + 1);
  localparam int OUT_W     = $clog2(TOTAL_OUT + 1);
  localparam int GAP_W     = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int TO_W      = $clog2(TIMEOUT + 1);

  localparam logic [RD_W-1:0]  RD_TGT  = RD_W'(TOTAL_RD);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(TOTAL_OUT);
  localparam logic [OUT_W:0]   OUT_TGT = (OUT_W + 1)'(TOTAL_OUT);
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PRIME, FEED, DRAIN, NEXT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [7:0]          frames_reg;
  logic [RD_W-1:0]     rd_cnt_reg;
  logic [GAP_W-1:0]    gap_cnt_reg;
  logic [OUT_W-1:0]    out_cnt_reg;
  logic                ovf_reg;
  logic                end_seen_reg;
  logic [TO_W-1:0]     drain_cnt_reg;
  logic                err_reg;
  logic                pad_vld_reg;

  logic                rd_fire;
  logic [OUT_W:0]      cnt_eff;
  logic                overflow;
  logic                frame_ok;
  logic                timeout;
  logic                err_set;

  // Count including a pulse arriving this cycle, so pad_end coinciding with
  // the final output strobe is accepted without an extra cycle.
  assign cnt_eff  = {1'b0, out_cnt_reg} + {{OUT_W{1'b0}}, pad_dout_vld};
  assign overflow = ovf_reg || ((out_cnt_reg == OUT_MAX) && pad_dout_vld);
  assign frame_ok = (cnt_eff == OUT_TGT) && (end_seen_reg || pad_end);
  assign timeout  = (drain_cnt_reg == TO_LAST);
  assign rd_fire  = (state_reg == FEED) && (gap_cnt_reg == '0) && (rd_cnt_reg != RD_TGT);

  always_comb begin
    state_next = state_reg;
    err_set    = 1'b0;
    case (state_reg)
      IDLE:  if (start) state_next = (frames != 8'd0) ? PRIME : DONE;
      PRIME: state_next = FEED;
      // Wait for the last read's pad_vld to go out before draining.
      FEED:  if ((rd_cnt_reg == RD_TGT) && pad_vld_reg) state_next = DRAIN;
      DRAIN: begin
        if (overflow) begin
          state_next = DONE;
          err_set    = 1'b1;
        end else if (frame_ok) begin
          state_next = NEXT;
        end else if (timeout) begin
          state_next = DONE;
          err_set    = 1'b1;
        end
      end
      NEXT:  state_next = (frames_reg == 8'd1) ? DONE : PRIME;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      err_set    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      frames_reg    <= '0;
      rd_cnt_reg    <= '0;
      gap_cnt_reg   <= '0;
      out_cnt_reg   <= '0;
      ovf_reg       <= 1'b0;
      end_seen_reg  <= 1'b0;
      drain_cnt_reg <= '0;
      err_reg       <= 1'b0;
      pad_vld_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pad_vld_reg <= rd_fire;

      if ((state_reg == IDLE) && start) begin
        addr_reg   <= base_addr;
        frames_reg <= frames;
        err_reg    <= 1'b0;
      end else if (rd_fire) begin
        // Frames are contiguous, so the address simply keeps counting.
        addr_reg <= addr_reg + 1'b1;
      end
      if (err_set) err_reg <= 1'b1;

      if (state_reg == NEXT) frames_reg <= frames_reg - 8'd1;

      if (state_reg == PRIME) begin
        rd_cnt_reg  <= '0;
        gap_cnt_reg <= '0;
      end else if (rd_fire) begin
        rd_cnt_reg  <= rd_cnt_reg + 1'b1;
        gap_cnt_reg <= GAP_LD;
      end else if (gap_cnt_reg != '0) begin
        gap_cnt_reg <= gap_cnt_reg - 1'b1;
      end

      // Output counter saturates at the expected total; an extra strobe is
      // remembered as an overflow instead of wrapping.
      if (state_reg == PRIME) begin
        out_cnt_reg  <= '0;
        ovf_reg      <= 1'b0;
        end_seen_reg <= 1'b0;
      end else if ((state_reg == FEED) || (state_reg == DRAIN)) begin
        if (pad_dout_vld) begin
          if (out_cnt_reg == OUT_MAX) ovf_reg <= 1'b1;
          else                        out_cnt_reg <= out_cnt_reg + 1'b1;
        end
        if (pad_end) end_seen_reg <= 1'b1;
      end

      if (state_reg == DRAIN) drain_cnt_reg <= drain_cnt_reg + 1'b1;
      else                    drain_cnt_reg <= '0;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign err       = err_reg;
  assign pad_ce    = (state_reg == PRIME) || (state_reg == FEED) || (state_reg == DRAIN);
  assign mem_rd_en = rd_fire;
  assign mem_addr  = addr_reg;
  assign pad_vld   = pad_vld_reg;
  assign pad_din   = pad_vld_reg ? mem_rd_data : '0;

endmodule

// File: tb/tb_pad_feed_ctrl.sv
// Bench for pad_feed_ctrl (SIZE=4, PADDING=1, GAP=2, TIMEOUT=64).
// Stimulus pushes expected read addresses and job results into queues; a
// negedge monitor pops and compares whenever the DUT reads, strobes pad_vld
// or pulses done.
module tb_pad_feed_ctrl;

  localparam int N = 8, CH = 3, SIZE = 4, PAD = 1, GAP = 2, AW = 16, TO = 64;
  localparam int W = CH * N;
  localparam int EXTRA = (SIZE + 2 * PAD) * (SIZE + 2 * PAD) - SIZE * SIZE;

  logic          clk, rst_n, start, abort;
  logic [AW-1:0] base_addr;
  logic [7:0]    frames;
  logic          busy, done, err, mem_rd_en, pad_ce, pad_vld;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_rd_data, pad_din;
  logic          pad_dout_vld, pad_end;

  pad_feed_ctrl #(.N(N), .CHANNEL(CH), .SIZE(SIZE), .PADDING(PAD), .GAP(GAP),
                  .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .base_addr(base_addr), .frames(frames), .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pad_ce(pad_ce), .pad_vld(pad_vld), .pad_din(pad_din),
    .pad_dout_vld(pad_dout_vld), .pad_end(pad_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8], a[7:0]};
  endfunction

  // Memory: registered read, data held between reads.
  always @(posedge clk) begin
    if (!rst_n) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= mem_word(mem_addr);
  end

  // Padding stage model: echoes each input as an output strobe, then emits the
  // border outputs with pad_end on the last; stall suppresses the border.
  int in_cnt, extra;
  bit stall;
  always @(negedge clk) begin
    if (!rst_n || !pad_ce) begin
      in_cnt = 0; extra = 0; pad_dout_vld = 1'b0; pad_end = 1'b0;
    end else begin
      pad_dout_vld = 1'b0; pad_end = 1'b0;
      if (pad_vld) begin
        in_cnt++; pad_dout_vld = 1'b1;
      end else if (in_cnt == SIZE * SIZE && !stall && extra < EXTRA) begin
        extra++; pad_dout_vld = 1'b1; pad_end = (extra == EXTRA);
      end
    end
  end

  typedef struct { bit err; int frames; int reads; } job_t;
  job_t          exp_job_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [W-1:0]  exp_din_q[$];

  int cyc = 0, last_rd_cyc = -1, job_reads = 0, job_edges = 0, low_run = 0, done_seen = 0;
  bit prev_pad_ce = 0, prev_done = 0;
  logic [AW-1:0] m_addr;
  job_t m_job;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      job_reads = 0; job_edges = 0; last_rd_cyc = -1; low_run = 0;
      prev_pad_ce = 0; prev_done = 0;
    end else begin
      if (!busy) begin job_reads = 0; job_edges = 0; last_rd_cyc = -1; end
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: addr 0x%0h, none expected", mem_addr);
        end else begin
          m_addr = exp_addr_q.pop_front();
          check("rd_addr", mem_addr, m_addr);
          exp_din_q.push_back(mem_word(m_addr));
        end
        if (last_rd_cyc >= 0) check("rd_spacing", cyc - last_rd_cyc, GAP + 1);
        last_rd_cyc = cyc;
        job_reads++;
      end
      if (pad_vld) begin
        if (exp_din_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_pad_vld: pad_din 0x%0h, none expected", pad_din);
        end else check("pad_din", pad_din, exp_din_q.pop_front());
      end else if (mem_rd_data != '0) begin
        check("pad_din_idle", pad_din, 0);
      end
      if (busy && prev_pad_ce && !pad_ce) begin job_edges++; last_rd_cyc = -1; end
      if (busy && !pad_ce) low_run++;
      else begin
        if (busy && pad_ce && low_run > 0) check("pad_ce_low_cycles", low_run, 1);
        low_run = 0;
      end
      if (done) begin
        check("done_width", prev_done, 0);
        if (exp_job_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done, none expected");
        end else begin
          m_job = exp_job_q.pop_front();
          check("done_err", err, m_job.err);
          check("job_frames", job_edges, m_job.frames);
          check("job_reads", job_reads, m_job.reads);
          $display("[TB] job done: frames %0d reads %0d err %0d", job_edges, job_reads, err);
        end
        done_seen++;
      end
      prev_pad_ce = pad_ce;
      prev_done   = done;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_job(input logic [AW-1:0] b, input int nfr, input bit e, input int reads);
    job_t j;
    for (int i = 0; i < reads; i++) exp_addr_q.push_back(b + AW'(i));
    j.err = e; j.frames = nfr; j.reads = reads;
    exp_job_q.push_back(j);
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [7:0] f);
    start = 1'b1; base_addr = b; frames = f;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name, output int n);
    int s;
    s = done_seen; n = 0;
    while (done_seen == s && n < budget) begin tick(); n++; end
    if (done_seen == s) begin
      tests++; fails++;
      $display("FAIL %s: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_mem_rd_en"}, mem_rd_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_pad_ce"}, pad_ce, 0);
    check({tag, "_pad_vld"}, pad_vld, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, snap;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; frames = '0; stall = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single frame at 0x100; a second start while busy must be ignored.
    push_job(16'h0100, 1, 1'b0, 16);
    do_start(16'h0100, 8'd1);
    repeat (10) tick();
    do_start(16'h0300, 8'd5);
    wait_done(300, "single_frame", n);
    tick();
    check("busy_after_done", busy, 0);

    // Three frames from address 0.
    push_job(16'h0000, 3, 1'b0, 48);
    do_start(16'h0000, 8'd3);
    wait_done(800, "three_frames", n);
    tick();

    // Stalled padding stage: drain timeout sets err and ends the job.
    stall = 1'b1;
    push_job(16'h0040, 1, 1'b1, 16);
    do_start(16'h0040, 8'd2);
    wait_done(400, "timeout_job", n);
    stall = 1'b0;
    tick();
    check("err_sticky", err, 1);
    check("busy_after_timeout", busy, 0);

    // Zero frames: immediate done, no reads, err cleared by the accepted start.
    push_job(16'h0000, 0, 1'b0, 0);
    do_start(16'h0777, 8'd0);
    wait_done(10, "zero_frames", n);
    check("zero_frames_latency_ok", (n <= 2) ? 1 : 0, 1);
    tick();
    check("err_cleared", err, 0);

    // Abort on the 8th read.
    for (int i = 0; i < 16; i++) exp_addr_q.push_back(16'h0200 + AW'(i));
    do_start(16'h0200, 8'd1);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      if (mem_rd_en) begin
        n++;
        if (n == 8) break;
      end
      tick();
    end
    check("abort_reads_before", n, 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_pad_ce", pad_ce, 0);
    check("abort_mem_rd_en", mem_rd_en, 0);
    exp_addr_q.delete();
    repeat (30) tick();
    push_job(16'h0500, 1, 1'b0, 16);
    do_start(16'h0500, 8'd1);
    wait_done(300, "after_abort", n);
    tick();

    // Reset mid-FEED: job discarded, no done afterwards.
    for (int i = 0; i < 32; i++) exp_addr_q.push_back(16'h0080 + AW'(i));
    do_start(16'h0080, 8'd2);
    repeat (20) tick();
    snap = done_seen;
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_din_q.delete();
    repeat (100) tick();
    check("no_done_after_reset", done_seen, snap);
    check("busy_after_reset", busy, 0);

    check("leftover_jobs", exp_job_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pad_feed_ctrl.md
PAD_FEED_CTRL -- requirements
Module: pad_feed_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, bits per channel sample.
REQ-002 SHALL have parameter CHANNEL, default 3, channels packed per pixel word.
REQ-003 SHALL have parameter SIZE, default 32, unpadded map edge length.
REQ-004 SHALL have parameter PADDING, default 1, border width applied by the downstream padding stage.
REQ-005 SHALL have parameter GAP, default 13, idle cycles between successive pixel reads.
REQ-006 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-007 SHALL have parameter TIMEOUT, default 4096, maximum DRAIN cycles.
REQ-008 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-009 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-010 SHALL have ports start (in, 1, one-cycle job request), abort (in, 1, cancel job), base_addr (in, ADDR_W, first pixel address), frames (in, 8, maps per job).
REQ-011 SHALL have ports busy (out, 1), done (out, 1, one-cycle job-complete pulse), err (out, 1, sticky drain timeout/count error).
REQ-012 SHALL have ports mem_rd_en (out, 1), mem_addr (out, ADDR_W), mem_rd_data (in, CHANNEL*N, valid exactly one cycle after mem_rd_en).
REQ-013 SHALL have ports pad_ce (out, 1), pad_vld (out, 1), pad_din (out, CHANNEL*N), pad_dout_vld (in, 1), pad_end (in, 1); these connect to the padding stage.

Function
REQ-014 SHALL implement FSM states IDLE, PRIME, FEED, DRAIN, NEXT, DONE.
REQ-015 IDLE: on start=1 with frames!=0, SHALL latch base_addr/frames, set busy=1, go PRIME; with frames==0, SHALL go DONE with no memory reads.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 PRIME: one cycle, pad_ce=1, out_cnt cleared, then FEED.
REQ-018 pad_ce SHALL be 1 in PRIME, FEED, DRAIN and 0 in IDLE, NEXT, DONE.
REQ-019 FEED: first mem_rd_en on FEED entry cycle, then one every GAP+1 cycles; exactly SIZE*SIZE reads per frame.
REQ-020 mem_addr SHALL equal frame base for the first read and increment by 1 per read; frame base advances by SIZE*SIZE per frame.
REQ-021 pad_vld SHALL equal mem_rd_en delayed one cycle; pad_din SHALL be mem_rd_data passed through combinationally (zero when pad_vld=0).
REQ-022 After the SIZE*SIZE-th read, FSM SHALL enter DRAIN once its pad_vld has been issued.
REQ-023 out_cnt SHALL count pad_dout_vld pulses in PRIME/FEED/DRAIN, width ceil(log2((SIZE+2*PADDING)^2+1)).
REQ-024 DRAIN: when out_cnt==(SIZE+2*PADDING)^2 and pad_end==1, SHALL go NEXT.
REQ-025 DRAIN exceeding TIMEOUT cycles, or out_cnt exceeding (SIZE+2*PADDING)^2, SHALL set err=1 and go DONE.
REQ-026 NEXT: one cycle (pad_ce=0 resets padding stage), decrement frames remaining; if 0 go DONE else PRIME.
REQ-027 DONE: done=1 for exactly one cycle, busy=0 next cycle, return IDLE.
REQ-028 abort=1 in any non-IDLE state SHALL force IDLE next cycle: pad_ce=0, mem_rd_en=0, busy=0, no done pulse, err unchanged; abort has priority over all transitions.
REQ-029 err SHALL clear only on reset or on an accepted start.

Reset
REQ-030 rst_n=0 SHALL force IDLE, busy=0, done=0, err=0, mem_rd_en=0, mem_addr=0, pad_ce=0, pad_vld=0, out_cnt=0, regardless of state.
REQ-031 Reset asserted mid-job SHALL discard the job; no done pulse after release.

Verification (SIZE=4, PADDING=1, GAP=2)
REQ-032 start, base_addr=0x100, frames=1, model padding -> 16 reads at 0x100..0x10F spaced 3 cycles, 36 pad_dout_vld counted, one done pulse, err=0.
REQ-033 frames=3, base_addr=0 -> reads 0x00..0x2F, pad_ce low exactly one cycle between frames, 3 frame completions, one done.
REQ-034 frames=0 -> done pulse within 2 cycles of start, zero mem_rd_en.
REQ-035 padding model stalled (pad_end never 1), TIMEOUT=64 -> err=1, done pulse, busy=0.
REQ-036 abort during 8th read -> next cycle IDLE, pad_ce=0, no further reads, no done; new start accepted afterwards.
REQ-037 rst_n=0 mid-FEED for 2 cycles -> all outputs at reset values; second start during busy ignored.
